// File: rtl/pool_lane_sequencer.sv
// Pooling-column control sequencer: drives per-lane {write,useUpper,useCurrent,useLower}
// words for KxK stride-K windows. Optional macro STALL_CNT_EN adds a stall-cycle counter port.
module pool_lane_sequencer #(
    parameter int W       = 16,
    parameter int N_UNITS = 4,
    parameter int WIN_W   = 8
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   start,
    input  logic [1:0]             ksize,
    input  logic [WIN_W-1:0]       num_windows,
    output logic                   col_req,
    output logic [WIN_W-1:0]       col_addr,
    input  logic                   col_valid,
    output logic [4*N_UNITS-1:0]   ctrl,
    input  logic [W*N_UNITS-1:0]   max_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W*N_UNITS-1:0]   out_data,
    output logic                   busy,
    output logic                   done
`ifdef STALL_CNT_EN
    ,
    output logic [15:0]            stall_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           k_q, k_d;
    logic [1:0]           col_cnt_q, col_cnt_d;
    logic [WIN_W-1:0]     win_left_q, win_left_d;
    logic [WIN_W-1:0]     col_addr_q, col_addr_d;
    logic                 out_valid_q, out_valid_d;
    logic [W*N_UNITS-1:0] out_data_q, out_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 hs;

    // Edge lanes have no neighbour above (lane 0) or below (last lane).
    function automatic logic [2:0] lane_use(input logic [1:0] k, input int lane);
        logic [2:0] u;
        case (k)
            2'd2:    u = 3'b011;
            2'd3:    u = 3'b111;
            default: u = 3'b010;
        endcase
        if (lane == 0) u[2] = 1'b0;
        if (lane == N_UNITS - 1) u[0] = 1'b0;
        return u;
    endfunction

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        col_cnt_d   = col_cnt_q;
        win_left_d  = win_left_q;
        col_addr_d  = col_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ctrl        = '0;
        col_req     = (state_q == S_FETCH);
        hs          = col_req & col_valid;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d        = (ksize == 2'd0) ? 2'd1 : ksize;
                    win_left_d = num_windows;
                    col_addr_d = '0;
                    col_cnt_d  = '0;
                    if (num_windows == '0) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_CLEAR;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                for (int i = 0; i < N_UNITS; i++) ctrl[4*i +: 4] = 4'b1000;
                col_cnt_d = '0;
                state_d   = S_FETCH;
            end
            S_FETCH: begin
                if (hs) begin
                    for (int i = 0; i < N_UNITS; i++) ctrl[4*i +: 4] = {1'b1, lane_use(k_q, i)};
                    col_addr_d = col_addr_q + WIN_W'(1);
                    if (col_cnt_q == k_q - 2'd1) begin
                        // Last negedge write has landed; max_in is settled at this edge.
                        out_data_d  = max_in;
                        out_valid_d = 1'b1;
                        col_cnt_d   = '0;
                        state_d     = S_DRAIN;
                    end else begin
                        col_cnt_d = col_cnt_q + 2'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    win_left_d  = win_left_q - WIN_W'(1);
                    if (win_left_q == WIN_W'(1)) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= S_IDLE;
            k_q         <= 2'd1;
            col_cnt_q   <= '0;
            win_left_q  <= '0;
            col_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            col_cnt_q   <= col_cnt_d;
            win_left_q  <= win_left_d;
            col_addr_q  <= col_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign col_addr  = col_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && start) begin
            stall_d = '0;
        end else if (((col_req && !col_valid) || (out_valid_q && !out_ready))
                     && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pool_lane_sequencer.sv
// Bench for pool_lane_sequencer: emulates the PoolingALU lanes and a column buffer,
// compares result words with a window-max model computed straight from the column data.
module tb_pool_lane_sequencer;

    localparam int W     = 16;
    localparam int N     = 4;
    localparam int WIN_W = 8;

    logic             CLK = 1'b0;
    logic             RSTn = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       ksize = '0;
    logic [WIN_W-1:0] num_windows = '0;
    logic             col_req;
    logic [WIN_W-1:0] col_addr;
    logic             col_valid = 1'b0;
    logic [4*N-1:0]   ctrl;
    logic [W*N-1:0]   max_in;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W*N-1:0]   out_data;
    logic             busy;
    logic             done;
`ifdef STALL_CNT_EN
    logic [15:0]      stall_cycles;
`endif

    pool_lane_sequencer #(.W(W), .N_UNITS(N), .WIN_W(WIN_W)) dut (
        .CLK(CLK), .RSTn(RSTn), .start(start), .ksize(ksize), .num_windows(num_windows),
        .col_req(col_req), .col_addr(col_addr), .col_valid(col_valid), .ctrl(ctrl),
        .max_in(max_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
`ifdef STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Column buffer contents, per address and lane.
    int up_m[256][N];
    int cur_m[256][N];
    int dn_m[256][N];
    int alu[N];

    initial for (int i = 0; i < N; i++) alu[i] = 0;

    // PoolingALU lane emulation: capture on negedge.
    always @(negedge CLK) begin
        for (int i = 0; i < N; i++) begin
            logic [3:0] c;
            int a, m;
            c = ctrl[4*i +: 4];
            a = int'(col_addr);
            if (c[3]) begin
                if (c[2:0] == 3'b000) begin
                    alu[i] = 0;
                end else begin
                    m = alu[i];
                    if (c[2] && up_m[a][i] > m) m = up_m[a][i];
                    if (c[1] && cur_m[a][i] > m) m = cur_m[a][i];
                    if (c[0] && dn_m[a][i] > m) m = dn_m[a][i];
                    alu[i] = m;
                end
            end
        end
    end

    always_comb begin
        max_in = '0;
        for (int i = 0; i < N; i++) max_in[W*i +: W] = W'(alu[i]);
    end

    function automatic logic [W*N-1:0] exp_window(input int k, input int w);
        logic [W*N-1:0] r;
        int m, a;
        r = '0;
        for (int i = 0; i < N; i++) begin
            m = 0;
            for (int j = 0; j < k; j++) begin
                a = (w * k + j) % 256;
                if (cur_m[a][i] > m) m = cur_m[a][i];
                if (k >= 2 && i != N - 1 && dn_m[a][i] > m) m = dn_m[a][i];
                if (k == 3 && i != 0 && up_m[a][i] > m) m = up_m[a][i];
            end
            r[W*i +: W] = W'(m);
        end
        return r;
    endfunction

    task automatic fill_random();
        for (int a = 0; a < 256; a++)
            for (int i = 0; i < N; i++) begin
                up_m[a][i]  = int'($urandom_range(0, 2000)) - 1000;
                cur_m[a][i] = int'($urandom_range(0, 2000)) - 1000;
                dn_m[a][i]  = int'($urandom_range(0, 2000)) - 1000;
            end
    endtask

    // Pass driver: records what the DUT does; tests compare afterwards.
    logic [W*N-1:0] got_q[$];
    int done_cnt, timeout, hold_viol, drain_req_viol, lane0_up, lane3_dn, stall_exp;
    int final_addr;

    task automatic drive_pass(input int k, input int nw, input int vmode, input int rmode);
        int cyc, low_left;
        bit prev_hold, held_once;
        logic [W*N-1:0] prev_data;
        got_q.delete();
        done_cnt = 0; timeout = 0; hold_viol = 0; drain_req_viol = 0;
        lane0_up = 0; lane3_dn = 0; stall_exp = 0; final_addr = -1;
        prev_hold = 0; held_once = 0; low_left = 0; prev_data = '0; cyc = 0;
        @(posedge CLK); #1;
        ksize = 2'(k); num_windows = WIN_W'(nw); start = 1'b1;
        col_valid = 1'b0; out_ready = 1'b0;
        while (1) begin
            @(posedge CLK); #1;
            cyc++;
            if (vmode == 1) begin
                start = 1'($urandom_range(0, 1));
                ksize = 2'($urandom_range(0, 3));
                num_windows = WIN_W'($urandom_range(0, 255));
            end else begin
                start = 1'b0;
            end
            if (prev_hold && (!out_valid || out_data !== prev_data)) hold_viol++;
            if (done) begin
                done_cnt++;
                final_addr = int'(col_addr);
            end
            col_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (rmode == 0) out_ready = 1'b1;
            else if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
            else begin
                if (out_valid && got_q.size() == 1 && !held_once) begin
                    held_once = 1; low_left = 5;
                end
                out_ready = (low_left == 0);
                if (low_left > 0) low_left--;
            end
            #1;
            if (out_valid && col_req) drain_req_viol++;
            if (ctrl[2]) lane0_up++;
            if (ctrl[12]) lane3_dn++;
            if (((col_req && !col_valid) || (out_valid && !out_ready)) && stall_exp < 65535)
                stall_exp++;
            if (out_valid && out_ready) got_q.push_back(out_data);
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            if (done) break;
            if (cyc > 5000) begin
                timeout = 1;
                break;
            end
        end
        start = 1'b0; col_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (col_req !== 1'b0) begin errors++; $display("FAIL reset_col_req got %b exp 0", col_req); end
        checks++; if (col_addr !== '0) begin errors++; $display("FAIL reset_col_addr got %h exp 0", col_addr); end
        checks++; if (ctrl !== '0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", ctrl); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b exp 00", busy, done); end
        @(posedge CLK); #1; RSTn = 1'b1;
    endtask

    task automatic test_ctrl_k2();
        fill_random();
        @(posedge CLK); #1;
        ksize = 2'd2; num_windows = 8'd1; start = 1'b1; col_valid = 1'b1; out_ready = 1'b1;
        @(posedge CLK); #1; start = 1'b0; #1;
        checks++; if (ctrl !== 16'h8888 || busy !== 1'b1) begin errors++; $display("FAIL k2_clear got ctrl %h busy %b exp 8888 1", ctrl, busy); end
        @(posedge CLK); #2;
        checks++; if (ctrl !== 16'hABBB || col_addr !== 8'd0) begin errors++; $display("FAIL k2_fetch0 got ctrl %h addr %0d exp abbb 0", ctrl, col_addr); end
        @(posedge CLK); #2;
        checks++; if (ctrl !== 16'hABBB || col_addr !== 8'd1) begin errors++; $display("FAIL k2_fetch1 got ctrl %h addr %0d exp abbb 1", ctrl, col_addr); end
        @(posedge CLK); #2;
        checks++; if (out_valid !== 1'b1 || ctrl !== '0 || col_req !== 1'b0) begin errors++; $display("FAIL k2_drain got valid %b ctrl %h req %b exp 1 0 0", out_valid, ctrl, col_req); end
        checks++; if (out_data !== exp_window(2, 0)) begin errors++; $display("FAIL k2_data got %h exp %h", out_data, exp_window(2, 0)); end
        @(posedge CLK); #2;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL k2_finish got done %b busy %b valid %b exp 1 0 0", done, busy, out_valid); end
        @(posedge CLK); #2;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL k2_done_pulse got %b exp 0", done); end
        col_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_k3_lanes();
        fill_random();
        up_m[0][1] = 5; cur_m[0][1] = -3; dn_m[0][1] = 7;
        up_m[1][1] = 2; cur_m[1][1] = 9;  dn_m[1][1] = 1;
        up_m[2][1] = 0; cur_m[2][1] = 0;  dn_m[2][1] = 4;
        drive_pass(3, 1, 1, 1);
        checks++; if (timeout != 0 || got_q.size() != 1) begin errors++; $display("FAIL k3_count got %0d exp 1 (timeout %0d)", got_q.size(), timeout); end
        else begin
            checks++; if (got_q[0][W +: W] !== 16'd9) begin errors++; $display("FAIL k3_lane1 got %0d exp 9", $signed(got_q[0][W +: W])); end
            checks++; if (got_q[0] !== exp_window(3, 0)) begin errors++; $display("FAIL k3_word got %h exp %h", got_q[0], exp_window(3, 0)); end
        end
        checks++; if (lane0_up != 0 || lane3_dn != 0) begin errors++; $display("FAIL k3_edge_mask got up0 %0d dn3 %0d exp 0 0", lane0_up, lane3_dn); end
    endtask

    task automatic test_negative_floor();
        for (int a = 0; a < 256; a++)
            for (int i = 0; i < N; i++) begin
                up_m[a][i] = -4; cur_m[a][i] = -4; dn_m[a][i] = -4;
            end
        drive_pass(1, 2, 1, 1);
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL floor_count got %0d exp 2", got_q.size()); end
        foreach (got_q[n]) begin
            checks++; if (got_q[n] !== '0) begin errors++; $display("FAIL floor_word%0d got %h exp 0", n, got_q[n]); end
        end
    endtask

    task automatic test_backpressure();
        fill_random();
        drive_pass(2, 3, 0, 2);
        checks++; if (got_q.size() != 3 || done_cnt != 1 || timeout != 0) begin errors++; $display("FAIL bp_counts got xfers %0d done %0d exp 3 1", got_q.size(), done_cnt); end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold got %0d changes exp 0", hold_viol); end
        checks++; if (drain_req_viol != 0) begin errors++; $display("FAIL bp_drain_req got %0d exp 0", drain_req_viol); end
        foreach (got_q[n]) begin
            checks++; if (got_q[n] !== exp_window(2, n)) begin errors++; $display("FAIL bp_word%0d got %h exp %h", n, got_q[n], exp_window(2, n)); end
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) begin
            int k, keff, nw;
            k = int'($urandom_range(0, 3));
            keff = (k == 0) ? 1 : k;
            nw = int'($urandom_range(1, 6));
            fill_random();
            drive_pass(k, nw, 1, 1);
            checks++; if (got_q.size() != nw || done_cnt != 1 || timeout != 0) begin errors++; $display("FAIL rand%0d_counts got xfers %0d done %0d exp %0d 1", p, got_q.size(), done_cnt, nw); end
            checks++; if (final_addr != (nw * keff) % 256) begin errors++; $display("FAIL rand%0d_addr got %0d exp %0d", p, final_addr, (nw * keff) % 256); end
            checks++; if (hold_viol != 0 || drain_req_viol != 0) begin errors++; $display("FAIL rand%0d_protocol got hold %0d req %0d exp 0 0", p, hold_viol, drain_req_viol); end
            foreach (got_q[n]) begin
                checks++; if (got_q[n] !== exp_window(keff, n)) begin errors++; $display("FAIL rand%0d_word%0d got %h exp %h", p, n, got_q[n], exp_window(keff, n)); end
            end
`ifdef STALL_CNT_EN
            checks++; if (int'(stall_cycles) != stall_exp) begin errors++; $display("FAIL rand%0d_stall got %0d exp %0d", p, stall_cycles, stall_exp); end
`endif
        end
    endtask

    task automatic test_wrap();
        fill_random();
        drive_pass(3, 90, 0, 0);
        checks++; if (final_addr != 14 || got_q.size() != 90) begin errors++; $display("FAIL wrap got addr %0d xfers %0d exp 14 90", final_addr, got_q.size()); end
        foreach (got_q[n]) begin
            if (got_q[n] !== exp_window(3, n)) begin
                checks++; errors++; $display("FAIL wrap_word%0d got %h exp %h", n, got_q[n], exp_window(3, n));
            end else checks++;
        end
    endtask

    task automatic test_zero_windows();
        @(posedge CLK); #1;
        ksize = 2'd1; num_windows = 8'd0; start = 1'b1;
        @(posedge CLK); #1; start = 1'b0; #1;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done got done %b busy %b exp 1 0", done, busy); end
`ifdef STALL_CNT_EN
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL zero_stall got %0d exp 0", stall_cycles); end
`endif
        @(posedge CLK); #2;
        checks++; if (done !== 1'b0 || col_req !== 1'b0) begin errors++; $display("FAIL zero_after got done %b req %b exp 0 0", done, col_req); end
    endtask

    task automatic test_reset_mid_pass();
        int xfers, cyc, dn;
        fill_random();
        @(posedge CLK); #1;
        ksize = 2'd2; num_windows = 8'd3; start = 1'b1; col_valid = 1'b1; out_ready = 1'b1;
        xfers = 0; cyc = 0;
        while (cyc < 200) begin
            @(posedge CLK); #1; start = 1'b0; cyc++;
            if (out_valid) xfers++;
            if (xfers == 1 && col_req) break;
        end
        checks++; if (cyc >= 200) begin errors++; $display("FAIL rst_reach_fetch got timeout exp window 2 fetch"); end
        #2; RSTn = 1'b0; #1;
        checks++; if (col_req !== 1'b0 || col_addr !== '0 || ctrl !== '0) begin errors++; $display("FAIL rst_async_req got req %b addr %h ctrl %h exp 0 0 0", col_req, col_addr, ctrl); end
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_async_out got valid %b data %h busy %b done %b exp zeros", out_valid, out_data, busy, done); end
        dn = 0;
        repeat (3) begin @(posedge CLK); #1; if (done) dn++; end
        RSTn = 1'b1;
        repeat (2) begin @(posedge CLK); #1; if (done) dn++; end
        checks++; if (dn != 0) begin errors++; $display("FAIL rst_no_done got %0d exp 0", dn); end
        drive_pass(1, 2, 1, 1);
        checks++; if (got_q.size() != 2 || done_cnt != 1) begin errors++; $display("FAIL rst_restart got xfers %0d done %0d exp 2 1", got_q.size(), done_cnt); end
        foreach (got_q[n]) begin
            checks++; if (got_q[n] !== exp_window(1, n)) begin errors++; $display("FAIL rst_word%0d got %h exp %h", n, got_q[n], exp_window(1, n)); end
        end
    endtask

    initial begin
        test_reset();
        test_ctrl_k2();
        test_k3_lanes();
        test_negative_floor();
        test_backpressure();
        test_zero_windows();
        test_random();
        test_wrap();
        test_reset_mid_pass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
